nibble_serial_adder: RTL
========================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 SHALL have parameter: NIBBLES, 4, number of 4-bit digits per operand (operand width W = 4*NIBBLES, NIBBLES >= 2).
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand set present.
REQ-005 SHALL have port: in_ready  output  1  block can accept operands.
REQ-006 SHALL have port: a  input  W  operand A.
REQ-007 SHALL have port: b  input  W  operand B.
REQ-008 SHALL have port: ci  input  1  carry-in of the whole sum.
REQ-009 SHALL have port: out_valid  output  1  result present.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result.
REQ-011 SHALL have port: s  output  W  registered sum.
REQ-012 SHALL have port: co  output  1  registered carry-out of the MSB nibble.

Function
REQ-013 SHALL compute {co,s} = a + b + ci, one nibble per clock, LSB nibble first, through one 4-bit carry-lookahead adder instance (propagate/generate form).
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; IDLE after reset.
REQ-015 SHALL drive in_ready = 1 only in IDLE; accept on in_valid && in_ready, latching a, b, ci into internal registers, clearing nibble counter to 0, moving to RUN.
REQ-016 SHALL, in RUN, add nibble[idx] of latched a and b with the registered carry (ci for idx 0), store the 4-bit sum into s[4*idx+3:4*idx], register the nibble carry, and increment idx.
REQ-017 SHALL leave RUN for DONE on the edge that processes idx = NIBBLES-1, loading co from that nibble's carry-out.
REQ-018 SHALL assert out_valid only in DONE; s and co SHALL be stable while out_valid = 1.
REQ-019 SHALL return to IDLE on out_valid && out_ready; no input accepted in that same cycle (in_ready low in DONE).
REQ-020 SHALL produce out_valid exactly NIBBLES cycles after the accepting edge when out_ready is high.
REQ-021 SHALL ignore changes on a, b, ci, in_valid while in RUN or DONE.
REQ-022 SHALL hold DONE indefinitely while out_ready = 0 (backpressure), no result overwritten.
REQ-023 SHALL wrap the nibble counter only via reload on accept; idx never exceeds NIBBLES-1.

Reset
REQ-024 SHALL, on rst_n low at any time including mid-RUN, immediately force state IDLE, idx 0, carry register 0, s 0, co 0, out_valid 0, in_ready 1 after release; partial results discarded.
REQ-025 SHALL resume accepting on the first rising clk edge after rst_n deasserts.

Configuration
REQ-026 SHALL support macro NIBBLE_SERIAL_ADDER_OVF_EN.
REQ-027 SHALL, with NIBBLE_SERIAL_ADDER_OVF_EN defined, add port ovf  output  1  signed two's-complement overflow of the W-bit sum (carry into MSB XOR carry out of MSB), registered with co, reset 0, stable in DONE.
REQ-028 SHALL, without the macro, have no ovf port and no overflow logic; all other behaviour identical.

Verification (NIBBLES = 4)
REQ-029 SHALL cover: a=0xFFFF, b=0x0001, ci=0 -> out_valid 4 cycles after accept, s=0x0000, co=1.
REQ-030 SHALL cover: a=0x1234, b=0x4321, ci=1 -> s=0x5556, co=0; a, b changed to 0xAAAA during RUN -> result unchanged.
REQ-031 SHALL cover: out_ready held 0 for 5 cycles after out_valid -> s, co, out_valid stable, in_ready 0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-032 SHALL cover: rst_n pulsed low during RUN idx=2 -> out_valid 0, s=0x0000, co=0 immediately; new op 0x0F0F+0x00F1 ci=0 afterwards -> s=0x1000, co=0.
REQ-033 SHALL cover, with NIBBLE_SERIAL_ADDER_OVF_EN: 0x7FFF+0x0001 ci=0 -> s=0x8000, co=0, ovf=1; 0xFFFF+0x0001 -> ovf=0.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit carry-lookahead slice reused LSB nibble first.
// Optional signed overflow output enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_cla4 (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       c3,
   output logic       c4
);
   logic [3:0] p;
   logic [3:0] g;
   logic [4:0] c;

   always_comb begin
      p    = x ^ y;
      g    = x & y;
      c[0] = cin;
      c[1] = g[0] | (p[0] & c[0]);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c[0]);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c[0]);
      sum  = p ^ c[3:0];
      c3   = c[3];
      c4   = c[4];
   end
endmodule

module nibble_serial_adder #(
   parameter  int NIBBLES = 4,
   localparam int W       = 4 * NIBBLES,
   localparam int IW      = $clog2(NIBBLES)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] s,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   output logic         ovf,
`endif
   output logic         co
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  s_q, s_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          c_q, c_d;
   logic          co_q, co_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   logic          ovf_q, ovf_d;
`endif

   logic [3:0] nib_sum;
   logic       nib_c3;
   logic       nib_c4;
   logic       last;

   nibble_serial_cla4 u_cla (
      .x   (a_q[4*idx_q +: 4]),
      .y   (b_q[4*idx_q +: 4]),
      .cin (c_q),
      .sum (nib_sum),
      .c3  (nib_c3),
      .c4  (nib_c4)
   );

   assign last = (idx_q == IW'(NIBBLES - 1));

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      idx_d   = idx_q;
      c_d     = c_q;
      co_d    = co_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               c_d     = ci;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d[4*idx_q +: 4] = nib_sum;
            c_d = nib_c4;
            if (last) begin
               co_d    = nib_c4;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
               ovf_d   = nib_c3 ^ nib_c4;
`endif
               state_d = DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         idx_q   <= '0;
         c_q     <= 1'b0;
         co_q    <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         idx_q   <= idx_d;
         c_q     <= c_d;
         co_q    <= co_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign s         = s_q;
   assign co        = co_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
   assign ovf       = ovf_q;
`endif

   // nib_c3 only feeds overflow; keep it referenced in the default build
   logic unused_c3;
   assign unused_c3 = nib_c3;
endmodule
